// File: rtl/rr_arb_mux_4_1.sv
// Registered 4:1 round-robin arbitrating mux: four valid/ready sources into one registered output beat.
// Define RR_ARB_MUX_FIXED_PRIO_EN to use fixed priority (channel 0 highest) in place of round-robin.
module rr_arb_mux_4_1 #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int unsigned N     = 4;
    localparam int unsigned IDX_W = 2;

    logic [W-1:0]     out_data_q, out_data_d;
    logic [IDX_W-1:0] out_sel_q,  out_sel_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] gidx;
    logic             xfer_in;
    logic [W-1:0]     win_data;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    // Fixed priority: scanning downward leaves the lowest requesting index as winner.
    always_comb begin
        grant = '0;
        gidx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                gidx     = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Round-robin: first requester after the last winner; the 2-bit sum wraps mod 4.
    always_comb begin
        grant = '0;
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = last_q + IDX_W'(k);
            if (!found && in_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                gidx        = cand;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (xfer_in) begin
            last_d = gidx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IDX_W'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Slot is free or drains this cycle; the grant never feeds back into itself.
    assign accept   = !out_valid_q || out_ready;
    assign in_ready = grant & {N{accept}};
    assign xfer_in  = |(in_valid & in_ready);

    always_comb begin
        win_data = d0;
        case (gidx)
            2'd0:    win_data = d0;
            2'd1:    win_data = d1;
            2'd2:    win_data = d2;
            2'd3:    win_data = d3;
            default: win_data = d0;
        endcase
    end

    // A new beat overwrites the register even while the old one drains.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        if (xfer_in) begin
            out_data_d  = win_data;
            out_sel_d   = gidx;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
